// File: rtl/rank_state_bank.sv
// Double-buffered per-layer rank/UV table: beats load the shadow bank, commit swaps it active.
// Read latency 1 cycle; cfg_ready drops while a loaded shadow bank waits for its swap.
module rank_state_bank #(
    parameter int NUM_LAYERS = 8,
    parameter int RANK_WIDTH = 10,
    parameter int LANES      = 2,
    localparam int LAYER_W   = $clog2(NUM_LAYERS)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cfg_valid,
    output logic                        cfg_ready,
    input  logic [LANES*RANK_WIDTH-1:0] cfg_data,
    input  logic                        cfg_last,
    input  logic                        commit,
    input  logic                        rd_en,
    input  logic [LAYER_W-1:0]          layer_idx,
    output logic                        rd_valid,
    output logic [RANK_WIDTH-1:0]       rank_no,
    output logic                        uv_en,
    output logic                        rd_err,
    output logic                        cfg_err,
    output logic                        shadow_full,
    output logic [7:0]                  bank_gen
);

    localparam int RB  = (NUM_LAYERS + LANES - 1) / LANES;
    localparam int TB  = RB + 1;
    localparam int BCW = $clog2(TB);
    localparam logic [BCW-1:0] RB_L = BCW'(RB);

    typedef enum logic [1:0] {IDLE, LOAD, FULL} state_t;

    state_t                  state;
    logic [BCW-1:0]          beat_cnt;
    logic                    bank_sel;
    logic                    commit_pend;
    logic [RANK_WIDTH-1:0]   rank_mem [2][NUM_LAYERS];
    logic [NUM_LAYERS-1:0]   uv_mem [2];

    logic                    sh;
    logic                    beat_fire;
    logic                    last_beat;
    logic                    bad_beat;
    logic                    accept_rank;
    logic                    swap;
    logic                    rank_we [NUM_LAYERS];
    logic [RANK_WIDTH-1:0]   rank_wd [NUM_LAYERS];

    assign cfg_ready   = rst_n && (state != FULL);
    assign shadow_full = (state == FULL);
    assign sh          = ~bank_sel;
    assign beat_fire   = cfg_valid && cfg_ready;
    assign last_beat   = (beat_cnt == RB_L);
    assign bad_beat    = beat_fire && (cfg_last != last_beat);
    assign accept_rank = beat_fire && !cfg_last && !last_beat;
    assign swap        = (state == FULL) && (commit || commit_pend);

    // Each layer is owned by exactly one beat/lane pair; lanes past the last layer never match.
    always_comb begin
        for (int i = 0; i < NUM_LAYERS; i++) begin
            rank_we[i] = accept_rank && (int'(beat_cnt) == i / LANES);
            rank_wd[i] = cfg_data[(i % LANES)*RANK_WIDTH +: RANK_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            beat_cnt    <= '0;
            bank_sel    <= 1'b0;
            commit_pend <= 1'b0;
            bank_gen    <= '0;
            cfg_err     <= 1'b0;
            rd_valid    <= 1'b0;
            rank_no     <= '0;
            uv_en       <= 1'b0;
            rd_err      <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                uv_mem[b] <= '0;
                for (int i = 0; i < NUM_LAYERS; i++)
                    rank_mem[b][i] <= '0;
            end
        end else begin
            if (swap) begin
                bank_sel    <= ~bank_sel;
                bank_gen    <= bank_gen + 8'd1;
                commit_pend <= 1'b0;
                state       <= IDLE;
            end else if (state != FULL) begin
                if (commit && state == LOAD)
                    commit_pend <= 1'b1;
                // A malformed beat wins over a same-cycle commit and drops the pending swap.
                if (bad_beat) begin
                    cfg_err     <= 1'b1;
                    beat_cnt    <= '0;
                    state       <= IDLE;
                    commit_pend <= 1'b0;
                end else if (beat_fire && last_beat) begin
                    uv_mem[sh] <= cfg_data[NUM_LAYERS-1:0];
                    beat_cnt   <= '0;
                    state      <= FULL;
                end else if (beat_fire) begin
                    beat_cnt <= beat_cnt + 1'b1;
                    state    <= LOAD;
                end
                for (int i = 0; i < NUM_LAYERS; i++)
                    if (rank_we[i])
                        rank_mem[sh][i] <= rank_wd[i];
            end

            // bank_sel is the pre-edge value here, so a read on the swap edge sees the old bank.
            if (rd_en) begin
                rd_valid <= 1'b1;
                if (int'(layer_idx) >= NUM_LAYERS) begin
                    rank_no <= '0;
                    uv_en   <= 1'b0;
                    rd_err  <= 1'b1;
                end else begin
                    rank_no <= rank_mem[bank_sel][layer_idx];
                    uv_en   <= uv_mem[bank_sel][layer_idx];
                    rd_err  <= 1'b0;
                end
            end else begin
                rd_valid <= 1'b0;
                rd_err   <= 1'b0;
            end
        end
    end

endmodule
